// File: rtl/md_pkg.sv
// Shared types for the molecular-dynamics position read path.
package md_pkg;

  localparam int PID_W           = 8;
  localparam int MEM_LATENCY_DEF = 2;

  typedef logic [PID_W-1:0] particle_id_t;

  typedef enum logic [2:0] {
    IDLE,
    READ_NUM,
    WAIT_NUM,
    LOAD_REF,
    SWEEP,
    NEXT_REF,
    DONE
  } rd_state_e;

endpackage

// File: rtl/pos_read_lat_timer.sv
// Cache-latency wait: loads a cycle count and reports expiry when it reaches zero.
module pos_read_lat_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [2:0] val_i,
  output logic       expired_o
);

  logic [2:0] cnt_q;

  // Down-counter that parks at zero until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= 3'd0;
    else if (load_i)         cnt_q <= val_i;
    else if (cnt_q != 3'd0)  cnt_q <= cnt_q - 3'd1;
  end

  assign expired_o = (cnt_q == 3'd0);

endmodule

// File: rtl/pos_read_ctrl.sv
// Position-cache read sequencer: fetches a cell's particle count, then walks
// reference/neighbour particle pairs, issuing one cache read per cycle.
module pos_read_ctrl
  import md_pkg::*;
#(
  parameter int ID_WIDTH    = PID_W,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                phase_cfg,
  input  logic                back_pressure,
  input  logic [ID_WIDTH-1:0] rd_data_count,
  input  logic                reading_done,
  output logic                rd_en,
  output logic [ID_WIDTH-1:0] rd_addr,
  output logic                phase,
  output logic                reading_particle_num,
  output logic [ID_WIDTH-1:0] ref_id,
  output logic [ID_WIDTH-1:0] particle_id,
  output logic [ID_WIDTH-1:0] ref_particle_count,
  output logic                busy,
  output logic                done
);

  // READ_NUM counts as the first latency cycle, so WAIT_NUM lasts MEM_LATENCY cycles.
  localparam logic [2:0]          LAT_LOAD = 3'(MEM_LATENCY - 1);
  localparam logic [ID_WIDTH:0]   ONE_X    = (ID_WIDTH+1)'(1);

  rd_state_e           state_q;
  logic [ID_WIDTH-1:0] ref_id_q, pid_q, cnt_q;
  logic                phase_q;
  logic                lat_exp;

  // One extra bit keeps id+1 from wrapping when count is at its maximum.
  logic [ID_WIDTH:0] ref_inc, pid_inc, cnt_x;
  logic              sweep_empty, sweep_rd;

  assign ref_inc     = {1'b0, ref_id_q} + ONE_X;
  assign pid_inc     = {1'b0, pid_q} + ONE_X;
  assign cnt_x       = {1'b0, cnt_q};
  assign sweep_empty = ({1'b0, pid_q} >= cnt_x);
  assign sweep_rd    = (state_q == SWEEP) && !reading_done && !sweep_empty && !back_pressure;

  pos_read_lat_timer u_lat (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_q == READ_NUM),
    .val_i     (LAT_LOAD),
    .expired_o (lat_exp)
  );

  // Read strobe/address decode; back_pressure and abort must gate reads in the same cycle.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    unique case (state_q)
      READ_NUM: rd_en = 1'b1;
      LOAD_REF: begin
        rd_en   = !reading_done;
        rd_addr = ref_inc[ID_WIDTH-1:0];
      end
      SWEEP: begin
        rd_en   = sweep_rd;
        rd_addr = sweep_rd ? pid_inc[ID_WIDTH-1:0] : '0;
      end
      default: ;
    endcase
  end

  assign reading_particle_num = (state_q == READ_NUM) || (state_q == WAIT_NUM);
  assign busy                 = (state_q != IDLE);
  assign done                 = (state_q == DONE);
  assign phase                = phase_q;
  assign ref_id               = ref_id_q;
  assign particle_id          = pid_q;
  assign ref_particle_count   = cnt_q;

  // Cell sequencing FSM with its id/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ref_id_q <= '0;
      pid_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          phase_q  <= phase_cfg;
          ref_id_q <= '0;
          pid_q    <= '0;
          cnt_q    <= '0;
          state_q  <= READ_NUM;
        end
        READ_NUM: state_q <= WAIT_NUM;
        WAIT_NUM: if (lat_exp) begin
          cnt_q   <= rd_data_count;
          state_q <= (rd_data_count == '0) ? DONE : LOAD_REF;
        end
        LOAD_REF: begin
          if (reading_done) state_q <= DONE;
          else begin
            pid_q   <= phase_q ? '0 : ref_inc[ID_WIDTH-1:0];
            state_q <= SWEEP;
          end
        end
        SWEEP: begin
          if (reading_done)      state_q <= DONE;
          else if (sweep_empty)  state_q <= NEXT_REF;
          else if (!back_pressure) begin
            pid_q <= pid_inc[ID_WIDTH-1:0];
            if (pid_inc == cnt_x) state_q <= NEXT_REF;
          end
        end
        NEXT_REF: begin
          if (reading_done) state_q <= DONE;
          else begin
            ref_id_q <= ref_inc[ID_WIDTH-1:0];
            state_q  <= (ref_inc == cnt_x) ? DONE : LOAD_REF;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_read_ctrl.sv
// Randomized bench for pos_read_ctrl against a pair-list reference model.
module tb_pos_read_ctrl;

  localparam int IDW = 8;
  localparam int LAT = 3;

  logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, phase_cfg = 1'b0;
  logic           back_pressure = 1'b0, reading_done = 1'b0;
  logic [IDW-1:0] rd_data_count = '0;
  logic           rd_en, phase, reading_particle_num, busy, done;
  logic [IDW-1:0] rd_addr, ref_id, particle_id, ref_particle_count;

  int checks = 0, failures = 0, cyc = 0;

  typedef struct { int addr; bit nostall; } rd_t;

  pos_read_ctrl #(.ID_WIDTH(IDW), .MEM_LATENCY(LAT)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .phase_cfg            (phase_cfg),
    .back_pressure        (back_pressure),
    .rd_data_count        (rd_data_count),
    .reading_done         (reading_done),
    .rd_en                (rd_en),
    .rd_addr              (rd_addr),
    .phase                (phase),
    .reading_particle_num (reading_particle_num),
    .ref_id               (ref_id),
    .particle_id          (particle_id),
    .ref_particle_count   (ref_particle_count),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_rd_en"}, rd_en, 0);
    chk({pfx, "_rd_addr"}, rd_addr, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_rpn"}, reading_particle_num, 0);
    chk({pfx, "_phase"}, phase, 0);
    chk({pfx, "_ref_id"}, ref_id, 0);
    chk({pfx, "_pid"}, particle_id, 0);
    chk({pfx, "_count"}, ref_particle_count, 0);
  endtask

  // One cell: the model lists every read the cell must issue (address 0, then
  // for each reference its own load followed by its neighbour sweep) and the
  // cycle of the done pulse when nothing stalls.
  // bp_pct<0 selects a single 5-cycle stall starting after the third read.
  task automatic run_cell(input int cnt, input bit ph, input int bp_pct,
                          input int abort_ref, input int rst_after, input bit noise);
    rd_t q[$];
    rd_t e;
    int  s, c0, ndone, reads, exp_off, n, lo, stall, abort_cyc;
    bit  rd_on;
    q.push_back('{0, 1'b1});
    exp_off = LAT + 2;
    for (int r = 0; r < cnt; r++) begin
      if (abort_ref >= 0 && r >= abort_ref) break;
      q.push_back('{r + 1, 1'b1});
      lo = ph ? 0 : r + 1;
      n  = cnt - lo;
      for (int k = lo; k < cnt; k++) q.push_back('{k + 1, 1'b0});
      exp_off += 2 + ((n > 0) ? n : 1);
    end
    if (bp_pct < 0) exp_off += 5;
    c0 = -100; ndone = 0; reads = 0; stall = 5; rd_on = 1'b0; abort_cyc = -1;

    @(posedge clk); #1;
    start = 1'b1; phase_cfg = ph; s = cyc;
    @(negedge clk);
    for (int i = 0; i < 40000 && ndone == 0; i++) begin
      @(posedge clk); #1;
      start     = noise && busy && ($urandom_range(0, 7) == 0);
      phase_cfg = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bp_pct < 0) begin
        back_pressure = (reads >= 3 && stall > 0);
        if (back_pressure) stall--;
      end else begin
        back_pressure = ($urandom_range(0, 99) < bp_pct);
      end
      rd_data_count = (cyc == c0 + LAT) ? cnt[IDW-1:0]
                                        : (cnt[IDW-1:0] ^ IDW'($urandom_range(1, 255)));
      if (abort_ref >= 0 && busy && ref_id == abort_ref && !rd_on) begin
        rd_on = 1'b1; abort_cyc = cyc;
      end
      reading_done = rd_on;
      @(negedge clk);
      if (back_pressure && q.size() > 0 && !q[0].nostall) chk("stall_rd_en", rd_en, 0);
      if (rd_en) begin
        reads++;
        if (q.size() == 0) chk("extra_read", rd_en, 0);
        else begin
          e = q.pop_front();
          chk("rd_addr", rd_addr, e.addr);
          if (e.addr == 0) begin
            chk("rpn", reading_particle_num, 1);
            c0 = cyc;
          end
        end
      end
      if (rst_after >= 0 && reads >= rst_after) begin
        #1 rst_n = 1'b0;
        #1 check_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; back_pressure = 1'b0; reading_done = 1'b0;
        repeat (LAT + 2) begin
          @(negedge clk);
          chk("post_rst_busy", busy, 0);
          chk("post_rst_done", done, 0);
        end
        return;
      end
      if (done) begin
        ndone++;
        chk("cnt_latched", ref_particle_count, cnt);
        chk("phase_latched", phase, ph);
        if (abort_ref >= 0) chk("abort_done_lat", cyc - abort_cyc, 1);
        else begin
          chk("ref_id_end", ref_id, cnt);
          if (bp_pct <= 0) chk("done_lat", cyc - s, exp_off);
        end
      end
    end
    chk("done_seen", ndone, 1);
    chk("reads_left", q.size(), 0);
    @(posedge clk); #1;
    start = 1'b0; back_pressure = 1'b0; reading_done = 1'b0; phase_cfg = 1'b0;
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int cnt, ab;
    repeat (3) @(posedge clk);
    #1 check_zero("rst");
    rst_n = 1'b1;

    run_cell(3, 1'b0,  0, -1, -1, 1'b0);   // home-home, 7 reads
    run_cell(3, 1'b1,  0, -1, -1, 1'b0);   // home-neighbour, 13 reads
    run_cell(0, 1'b0,  0, -1, -1, 1'b0);   // empty cell
    run_cell(4, 1'b0, -1, -1, -1, 1'b0);   // 5-cycle stall mid-sweep
    run_cell(5, 1'b1,  0,  1, -1, 1'b0);   // abort at ref 1
    run_cell(4, 1'b0, 20,  2, -1, 1'b1);   // abort with stalls
    run_cell(5, 1'b1,  0, -1,  6, 1'b0);   // reset during sweep
    run_cell(2, 1'b1,  0, -1, -1, 1'b0);   // clean run after reset
    run_cell(3, 1'b0,  0, -1,  1, 1'b0);   // reset while count is in flight
    run_cell(1, 1'b1, 30, -1, -1, 1'b1);

    for (int t = 0; t < 12; t++) begin
      cnt = $urandom_range(0, 9);
      ab  = (cnt >= 3 && $urandom_range(0, 3) == 0) ? $urandom_range(1, cnt - 1) : -1;
      run_cell(cnt, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 30 : 0,
               ab, -1, 1'($urandom_range(0, 1)));
    end

    run_cell(255, 1'b0, 0, -1, -1, 1'b0);  // maximum count, ids reach the top of range

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
